// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 device-side transmitter: FSM encoding, frame size,
// parity helper and common scan-code prefixes.
package ps2_pkg;

  localparam int unsigned FRAME_BITS = 11;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StLoad = 3'd1;
  localparam state_t StHigh = 3'd2;
  localparam state_t StLow  = 3'd3;
  localparam state_t StGap  = 3'd4;

  localparam logic [7:0] BREAK = 8'hF0;
  localparam logic [7:0] EXT   = 8'hE0;

  // Odd parity: the parity bit makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_kbd_tx_if.sv
// Local-logic push interface and PS/2 line outputs of the keyboard-end transmitter.
interface ps2_kbd_tx_if;

  logic [7:0] wdata;
  logic       we;
  logic       full;
  logic       empty;
  logic       busy;
  logic       overflow;
  logic       ps2_clk;
  logic       ps2_data;

  modport master (
    output wdata, we,
    input  full, empty, busy, overflow, ps2_clk, ps2_data
  );

  modport slave (
    input  wdata, we,
    output full, empty, busy, overflow, ps2_clk, ps2_data
  );

endinterface

// File: rtl/ps2_tx_fifo.sv
// Synchronous byte FIFO with registered pointers, full/empty flags and a sticky overflow
// flag that is set whenever a push is attempted while full.
module ps2_tx_fifo #(
  parameter int unsigned FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] wdata_i,
  input  logic       we_i,
  input  logic       re_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       overflow_o
);

  localparam int unsigned Depth = 2 ** FIFO_AW;

  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               overflow_q;
  logic [7:0]         mem_q [Depth];
  logic               push, pop;

  assign full_o     = (count_q == (FIFO_AW + 1)'(Depth));
  assign empty_o    = (count_q == '0);
  assign overflow_o = overflow_q;
  assign rdata_o    = mem_q[rd_ptr_q];

  assign push = we_i & ~full_o;
  assign pop  = re_i & ~empty_o;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      // A drop while full is sticky even if a pop frees a slot in the same cycle.
      if (we_i && full_o) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard-end transmitter: pops queued scan codes and serializes each as an 11-bit
// frame (start, 8 data LSB first, odd parity, stop) followed by an idle gap.
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2000,
  parameter int unsigned GAP_CYCLES = 4000,
  parameter int unsigned FIFO_AW    = 3
) (
  input logic         clk,
  input logic         clrn,
  ps2_kbd_tx_if.slave tx_io
);

  localparam int unsigned DivW = ($clog2(CLK_DIV) > $clog2(GAP_CYCLES)) ?
                                 $clog2(CLK_DIV) : $clog2(GAP_CYCLES);

  state_t                state_q, state_d;
  logic [DivW-1:0]       div_q, div_d;
  logic [3:0]            bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  clk_q, clk_d;
  logic                  data_q, data_d;

  logic [7:0] fifo_rdata;
  logic       fifo_empty, fifo_full, fifo_overflow;
  logic       pop;

  assign pop = (state_q == StIdle) && !fifo_empty;

  ps2_tx_fifo #(
    .FIFO_AW(FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .clrn      (clrn),
    .wdata_i   (tx_io.wdata),
    .we_i      (tx_io.we),
    .re_i      (pop),
    .rdata_o   (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .overflow_o(fifo_overflow)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    clk_d   = clk_q;
    data_d  = data_q;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          shift_d = {1'b1, odd_parity(fifo_rdata), fifo_rdata, 1'b0};
          bit_d   = '0;
          div_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        data_d  = shift_q[0];
        clk_d   = 1'b1;
        div_d   = '0;
        state_d = StHigh;
      end
      StHigh: begin
        if (div_q == DivW'(CLK_DIV - 1)) begin
          div_d   = '0;
          clk_d   = 1'b0;
          state_d = StLow;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StLow: begin
        if (div_q == DivW'(CLK_DIV - 1)) begin
          div_d = '0;
          clk_d = 1'b1;
          if (bit_q == 4'(FRAME_BITS - 1)) begin
            data_d  = 1'b1;
            state_d = StGap;
          end else begin
            // Data moves only with the rising clock so it is stable at every fall.
            bit_d   = bit_q + 1'b1;
            data_d  = shift_q[1];
            shift_d = shift_q >> 1;
            state_d = StHigh;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StGap: begin
        if (div_q == DivW'(GAP_CYCLES - 1)) begin
          div_d   = '0;
          state_d = StIdle;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      clk_q   <= 1'b1;
      data_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      clk_q   <= clk_d;
      data_q  <= data_d;
    end
  end

  assign tx_io.full     = fifo_full;
  assign tx_io.empty    = fifo_empty;
  assign tx_io.overflow = fifo_overflow;
  assign tx_io.busy     = (state_q != StIdle);
  assign tx_io.ps2_clk  = clk_q;
  assign tx_io.ps2_data = data_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: a line monitor decodes frames at ps2_clk falls and
// compares them with frames built from the byte values and timing rules.
module tb_ps2_kbd_tx;
  import ps2_pkg::*;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned GAP     = 8;

  logic clk  = 1'b0;
  logic clrn = 1'b1;

  ps2_kbd_tx_if tx ();

  ps2_kbd_tx #(
    .CLK_DIV   (CLK_DIV),
    .GAP_CYCLES(GAP),
    .FIFO_AW   (3)
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .tx_io(tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;
  int last_push;

  int          fall_q[$];
  int          rise_q[$];
  int          start_q[$];
  logic [10:0] frame_q[$];
  logic [10:0] cur;
  int          nb = 0;

  // Line monitor: bits are sampled at ps2_clk falls; a reset discards a partial frame.
  always @(negedge tx.ps2_clk or negedge clrn) begin
    if (!clrn) begin
      nb = 0;
    end else begin
      cur[nb] = tx.ps2_data;
      nb++;
      fall_q.push_back(cyc);
      if (nb == 11) begin
        frame_q.push_back(cur);
        nb = 0;
      end
    end
  end

  always @(posedge tx.ps2_clk) if (clrn) rise_q.push_back(cyc);
  always @(negedge tx.ps2_data) if (clrn && nb == 0) start_q.push_back(cyc);

  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b, 1'b0};
  endfunction

  function automatic int qi(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1000;
  endfunction

  function automatic logic [10:0] fq(input int i);
    if (i < frame_q.size()) return frame_q[i];
    return 11'bx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    tx.we    = 1'b1;
    tx.wdata = b;
    @(posedge clk);
    #1;
    last_push = cyc;
    tx.we     = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int i = 0;
    while ((tx.busy || !tx.empty) && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk(tag, 32'(i < budget), 32'd1);
  endtask

  task automatic clear_logs();
    fall_q.delete();
    rise_q.delete();
    start_q.delete();
    frame_q.delete();
  endtask

  int          n0;
  int          k;
  int          w;
  logic [7:0]  b;
  logic [7:0]  exp_b[$];

  initial begin
    tx.we    = 1'b0;
    tx.wdata = 8'h00;
    #2 clrn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ps2_clk", 32'(tx.ps2_clk), 32'd1);
    chk("rst_ps2_data", 32'(tx.ps2_data), 32'd1);
    chk("rst_empty", 32'(tx.empty), 32'd1);
    chk("rst_full", 32'(tx.full), 32'd0);
    chk("rst_busy", 32'(tx.busy), 32'd0);
    chk("rst_overflow", 32'(tx.overflow), 32'd0);
    @(negedge clk) clrn = 1'b1;

    // Single frame: latency, bit values, frame length.
    clear_logs();
    push(8'h1C);
    n0 = last_push;
    repeat (2) begin @(posedge clk); #1; end
    chk("busy_in_frame", 32'(tx.busy), 32'd1);
    wait_idle(200, "idle_1c");
    chk("start_latency", qi(start_q, 0) - n0, 32'd2);
    chk("first_fall", qi(fall_q, 0) - n0, 2 + CLK_DIV);
    chk("fall_count", fall_q.size(), 32'd11);
    chk("frame_1c", 32'(fq(0)), 32'(exp_frame(8'h1C)));
    chk("frame_len", qi(rise_q, 10) - qi(start_q, 0), 22 * CLK_DIV);

    // Break prefix then make code, back to back.
    clear_logs();
    push(BREAK);
    push(8'h1C);
    wait_idle(400, "idle_f0_1c");
    chk("nframes_f0_1c", frame_q.size(), 32'd2);
    chk("frame_f0", 32'(fq(0)), 32'(exp_frame(BREAK)));
    chk("f0_parity", 32'(fq(0)), 32'(exp_frame(BREAK)) | 32'h200);
    chk("frame_1c_b", 32'(fq(1)), 32'(exp_frame(8'h1C)));
    chk("gap_f0_1c", qi(start_q, 1) - qi(rise_q, 10), GAP + 2);

    // Overflow: ten consecutive pushes from idle.
    clear_logs();
    for (int i = 0; i < 10; i++) begin
      push(8'(i));
      if (i == 8) begin
        chk("full_after_8", 32'(tx.full), 32'd1);
        chk("no_ovf_yet", 32'(tx.overflow), 32'd0);
      end
      if (i == 9) begin
        chk("ovf_set", 32'(tx.overflow), 32'd1);
        chk("full_kept", 32'(tx.full), 32'd1);
      end
    end
    wait_idle(1200, "idle_ovf");
    chk("nframes_ovf", frame_q.size(), 32'd9);
    for (int i = 0; i < 9; i++) chk($sformatf("ovf_frame%0d", i), 32'(fq(i)),
                                    32'(exp_frame(8'(i))));

    // Random bursts with random spacing, never exceeding the FIFO.
    for (int r = 0; r < 3; r++) begin
      clear_logs();
      exp_b.delete();
      k = $urandom_range(1, 6);
      for (int j = 0; j < k; j++) begin
        b = 8'($urandom);
        if (r == 0 && j == 0) b = EXT;
        exp_b.push_back(b);
        push(b);
        w = $urandom_range(0, 3);
        repeat (w) @(posedge clk);
      end
      wait_idle(k * 120 + 50, $sformatf("idle_rand%0d", r));
      chk($sformatf("nframes_rand%0d", r), frame_q.size(), k);
      for (int j = 0; j < k; j++) chk($sformatf("rand%0d_frame%0d", r, j), 32'(fq(j)),
                                      32'(exp_frame(exp_b[j])));
    end
    chk("ovf_sticky", 32'(tx.overflow), 32'd1);

    // Reset after the 5th fall: truncated frame, queued byte lost.
    clear_logs();
    push(8'($urandom));
    push(8'($urandom));
    w = 0;
    while (fall_q.size() < 5 && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("wait_5th_fall", 32'(w < 200), 32'd1);
    clrn = 1'b0;
    #1;
    chk("midrst_ps2_clk", 32'(tx.ps2_clk), 32'd1);
    chk("midrst_ps2_data", 32'(tx.ps2_data), 32'd1);
    chk("midrst_empty", 32'(tx.empty), 32'd1);
    chk("midrst_busy", 32'(tx.busy), 32'd0);
    chk("midrst_ovf_clr", 32'(tx.overflow), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) clrn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_frame", frame_q.size(), 32'd0);
    push(8'h1B);
    wait_idle(200, "idle_1b");
    chk("frame_1b", 32'(fq(0)), 32'(exp_frame(8'h1B)));

    // Back-to-back identical frames.
    clear_logs();
    push(8'h1B);
    push(8'h1B);
    wait_idle(400, "idle_b2b");
    chk("nframes_b2b", frame_q.size(), 32'd2);
    chk("b2b_frame1", 32'(fq(1)), 32'(exp_frame(8'h1B)));
    chk("b2b_gap", qi(start_q, 1) - qi(rise_q, 10), GAP + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
